// File: rtl/req_encoder_8to3.sv
// Request encoder: accepts an N-bit request vector and emits the index of
// each set bit, lowest index first, one code per consumer handshake.
// An all-zero vector is rejected with a one-cycle err_zero pulse.
module req_encoder_8to3 #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_vec,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         err_zero,
  output logic [7:0]   emit_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic         err_nxt;
  logic [7:0]   cnt_nxt;
  logic         accept;
  logic         handoff;
  logic         single_bit;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = i[W-1:0];
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves zero only when exactly one bit is set.
  function automatic logic is_single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE)) == '0);
  endfunction

  assign single_bit = is_single(pending);
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == EMIT);
  assign accept     = in_valid & in_ready;
  assign handoff    = out_valid & out_ready;

  // Outputs come only from registered state and read zero when idle.
  assign out_code = out_valid ? lowest_idx(pending) : '0;
  assign out_last = out_valid & single_bit;

  // Next-state logic: accept a vector in IDLE, retire one bit per handoff in EMIT.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    err_nxt     = 1'b0;
    cnt_nxt     = emit_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_vec != '0) begin
            pending_nxt = in_vec;
            state_nxt   = EMIT;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (handoff) begin
          pending_nxt = pending & (pending - ONE);
          cnt_nxt     = emit_cnt + 8'd1;
          if (single_bit) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over any accept or handoff in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      err_zero <= 1'b0;
      emit_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      err_zero <= err_nxt;
      emit_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Directed testbench for req_encoder_8to3.
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       err_zero;
  logic [7:0] emit_cnt;

  int total = 0;
  int passed = 0;

  req_encoder_8to3 #(.N(8), .W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_last(out_last), .err_zero(err_zero),
    .emit_cnt(emit_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, out_code, out_last, err_zero, emit_cnt} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0})
      $display("FAIL reset: ready=%0b valid=%0b code=%0d last=%0b err=%0b cnt=%0d, required 1 0 0 0 0 0",
               in_ready, out_valid, out_code, out_last, err_zero, emit_cnt);
    else passed++;
  endtask

  task automatic test_basic();
    logic [2:0] exp_code [3];
    exp_code[0] = 3'd2; exp_code[1] = 3'd5; exp_code[2] = 3'd7;
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 8'b1010_0100;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({out_valid, in_ready, out_code, out_last} !== {1'b1, 1'b0, exp_code[k], (k == 2)})
        $display("FAIL basic_code%0d: valid=%0b ready=%0b code=%0d last=%0b, required 1 0 %0d %0b",
                 k, out_valid, in_ready, out_code, out_last, exp_code[k], (k == 2));
      else passed++;
      step();
    end
    total++;
    if ({in_ready, out_valid, out_code, out_last, emit_cnt} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'd3})
      $display("FAIL basic_done: ready=%0b valid=%0b code=%0d last=%0b cnt=%0d, required 1 0 0 0 3",
               in_ready, out_valid, out_code, out_last, emit_cnt);
    else passed++;
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_vec = 8'h00;
    step();
    in_valid = 1'b0;
    total++;
    if ({err_zero, out_valid, in_ready} !== 3'b101)
      $display("FAIL zero_pulse: err=%0b valid=%0b ready=%0b, required 1 0 1", err_zero, out_valid, in_ready);
    else passed++;
    step();
    total++;
    if ({err_zero, out_valid, emit_cnt} !== {1'b0, 1'b0, 8'd3})
      $display("FAIL zero_after: err=%0b valid=%0b cnt=%0d, required 0 0 3", err_zero, out_valid, emit_cnt);
    else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_vec = 8'h81;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({out_valid, out_code, out_last, emit_cnt} !== {1'b1, 3'd0, 1'b0, 8'd3})
        $display("FAIL stall_hold%0d: valid=%0b code=%0d last=%0b cnt=%0d, required 1 0 0 3",
                 k, out_valid, out_code, out_last, emit_cnt);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    total++;
    if ({out_valid, out_code, out_last} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL stall_first: valid=%0b code=%0d last=%0b, required 1 0 0", out_valid, out_code, out_last);
    else passed++;
    step();
    total++;
    if ({out_valid, out_code, out_last} !== {1'b1, 3'd7, 1'b1})
      $display("FAIL stall_second: valid=%0b code=%0d last=%0b, required 1 7 1", out_valid, out_code, out_last);
    else passed++;
    step();
    total++;
    if ({in_ready, out_valid, emit_cnt} !== {1'b1, 1'b0, 8'd5})
      $display("FAIL stall_done: ready=%0b valid=%0b cnt=%0d, required 1 0 5", in_ready, out_valid, emit_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; in_vec = 8'hFF;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    total++;
    if ({out_valid, out_code, emit_cnt} !== {1'b1, 3'd3, 8'd8})
      $display("FAIL midrst_pre: valid=%0b code=%0d cnt=%0d, required 1 3 8", out_valid, out_code, emit_cnt);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, out_code, emit_cnt} !== {1'b1, 1'b0, 3'd0, 8'd0})
      $display("FAIL midrst: ready=%0b valid=%0b code=%0d cnt=%0d, required 1 0 0 0",
               in_ready, out_valid, out_code, emit_cnt);
    else passed++;
    step();
    total++;
    if ({out_valid, emit_cnt} !== {1'b0, 8'd0})
      $display("FAIL midrst_after: valid=%0b cnt=%0d, required 0 0", out_valid, emit_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic bad;
    out_ready = 1'b1;
    for (int v = 0; v < 86; v++) begin
      in_valid = 1'b1; in_vec = 8'hFF;
      step();
      in_vec = 8'h0F;
      bad = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if ({out_valid, out_code, out_last} !== {1'b1, 3'(j), (j == 7)}) bad = 1'b1;
        step();
      end
      total++;
      if (bad)
        $display("FAIL b2b_vec%0d: code sequence wrong, last seen code=%0d valid=%0b", v, out_code, out_valid);
      else passed++;
    end
    in_valid = 1'b0;
    total++;
    if ({emit_cnt, in_ready} !== {8'd176, 1'b1})
      $display("FAIL b2b_wrap: cnt=%0d ready=%0b, required 176 1", emit_cnt, in_ready);
    else passed++;
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1; in_valid = 1'b1; in_vec = 8'h01 << i;
      step();
      in_valid = 1'b0;
      total++;
      if ({out_valid, out_code, out_last, err_zero} !== {1'b1, 3'(i), 1'b1, 1'b0})
        $display("FAIL single%0d: valid=%0b code=%0d last=%0b err=%0b, required 1 %0d 1 0",
                 i, out_valid, out_code, out_last, err_zero, i);
      else passed++;
      step();
      total++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL single%0d_done: ready=%0b valid=%0b, required 1 0", i, in_ready, out_valid);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_single();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/req_encoder_8to3.md
REQ_ENCODER_8TO3 -- requirements
Module: req_encoder_8to3

Interface
REQ-001 Parameter N, default 8, SHALL be the request vector width; only N = 8 is supported.
REQ-002 Parameter W, default 3, SHALL be the code width and SHALL equal clog2(N).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 in_valid  input  1  SHALL indicate in_vec holds a request vector.
REQ-006 in_vec  input  N  SHALL carry the request vector; bit i set = request for code i.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a vector this cycle.
REQ-008 out_valid  output  1  SHALL indicate out_code/out_last are valid.
REQ-009 out_ready  input  1  SHALL indicate the consumer takes the current code.
REQ-010 out_code  output  W  SHALL be the binary index of the code being offered.
REQ-011 out_last  output  1  SHALL mark the final code of the current vector.
REQ-012 err_zero  output  1  SHALL pulse when an all-zero vector is accepted.
REQ-013 emit_cnt  output  8  SHALL count codes handed off since reset, wrapping.

Function
REQ-014 FSM SHALL have two states: IDLE, EMIT.
REQ-015 in_ready SHALL be 1 exactly when state = IDLE; out_valid SHALL be 1 exactly when state = EMIT.
REQ-016 Accept = in_valid & in_ready; on accept with in_vec != 0, pending register SHALL load in_vec and state SHALL go EMIT next cycle (1-cycle latency to out_valid).
REQ-017 On accept with in_vec = 0, state SHALL stay IDLE, pending unchanged, err_zero SHALL be 1 for exactly the next cycle.
REQ-018 err_zero SHALL be 0 in all other cycles.
REQ-019 In EMIT, out_code SHALL be the index of the lowest set bit of pending (bit 0 highest priority).
REQ-020 In EMIT, out_last SHALL be 1 iff pending has exactly one bit set.
REQ-021 out_code and out_last SHALL depend only on registered state, no combinational path from inputs.
REQ-022 Handoff = out_valid & out_ready; on handoff the offered bit SHALL be cleared in pending and emit_cnt SHALL increment by 1 (255 -> 0).
REQ-023 Handoff with out_last = 1 SHALL return state to IDLE next cycle; in_ready rises that cycle, no back-to-back acceptance in the handoff cycle.
REQ-024 With out_valid = 1 and out_ready = 0, out_code, out_last and pending SHALL hold unchanged.
REQ-025 in_valid and in_vec SHALL be ignored while in EMIT.
REQ-026 out_code and out_last SHALL be 0 when out_valid = 0.
REQ-027 A vector with k set bits SHALL produce exactly k handoffs in ascending index order.

Reset
REQ-028 rst = 1 at a clock edge SHALL force state IDLE, pending 0, emit_cnt 0, err_zero 0.
REQ-029 After reset: in_ready = 1, out_valid = 0, out_code = 0, out_last = 0.
REQ-030 Reset asserted mid-EMIT SHALL abort the vector; remaining pending bits SHALL be discarded with no further handoffs.
REQ-031 rst SHALL take priority over any simultaneous accept or handoff in the same cycle.

Verification
REQ-032 Reset, out_ready = 1, accept in_vec = 8'b1010_0100 -> codes 2, 5, 7 on consecutive cycles, out_last only with 7, emit_cnt = 3, in_ready back to 1 the cycle after code 7.
REQ-033 Accept in_vec = 8'h00 -> err_zero = 1 for one cycle, out_valid stays 0, emit_cnt unchanged.
REQ-034 Accept 8'h81, hold out_ready = 0 for 4 cycles -> out_code = 0 stable, out_last = 0; then out_ready = 1 -> code 0, then code 7 with out_last = 1.
REQ-035 Accept 8'hFF, rst = 1 after the 3rd handoff -> next cycle in_ready = 1, out_valid = 0, emit_cnt = 0.
REQ-036 Issue 86 vectors of 8'hFF with out_ready = 1 -> emit_cnt wraps to 688 mod 256 = 176; in_vec changes during EMIT have no effect.
REQ-037 Single-bit vectors 8'h01 .. 8'h80 -> out_code 0 .. 7 each with out_last = 1 on the first offer.
